// File: rtl/ov7670_pkg.sv
// Shared types for the synthetic OV7670 source: FSM states, test patterns
// and the RGB444 two-byte packing used on the camera data bus.
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_t;

  typedef enum logic [1:0] {
    PAT_BARS,
    PAT_RAMP,
    PAT_CHECK,
    PAT_ZEBRA
  } pattern_t;

  // rgb = {R, G, B}; the even byte carries R, the odd byte carries {G, B}
  function automatic logic [7:0] pack_rgb444(input logic [11:0] rgb, input logic odd);
    return odd ? rgb[7:0] : {4'h0, rgb[11:8]};
  endfunction

endpackage

// File: rtl/ov7670_pattern_pixel.sv
// Combinational pattern generator: pixel coordinate and pattern -> RGB444.
// The colour-bar index comes from the parent's bar-width counter.
module ov7670_pattern_pixel
  import ov7670_pkg::*;
#(
  parameter int IMG_HEIGHT = 240
) (
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic [2:0]  bar_i,
  input  pattern_t    pattern_i,
  output logic [11:0] rgb_o
);

  always_comb begin
    rgb_o = '0;
    case (pattern_i)
      PAT_BARS:  rgb_o = {{4{bar_i[2]}}, {4{bar_i[1]}}, {4{bar_i[0]}}};
      PAT_RAMP:  rgb_o = {3{x_i[7:4]}};
      PAT_CHECK: rgb_o = (x_i[4] ^ y_i[4]) ? '1 : '0;
      PAT_ZEBRA: rgb_o = ((y_i >= 16'(IMG_HEIGHT / 2)) && ((x_i % 16'd64) < 16'd32)) ? '1 : '0;
      default:   rgb_o = '0;
    endcase
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// Synthetic OV7670 byte-stream source: frame FSM, line/column counters and
// registered VSYNC/HREF/data outputs in RGB444 two-bytes-per-pixel format.
module ov7670_stream_gen
  import ov7670_pkg::*;
#(
  parameter int IMG_WIDTH   = 320,
  parameter int IMG_HEIGHT  = 240,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       vsync,
  output logic       href,
  output logic [7:0] d,
  output logic       frame_done,
  output logic       busy
);

  localparam int LINE_LEN = 2 * IMG_WIDTH + H_BLANK;
  localparam int CW       = $clog2(LINE_LEN);
  localparam int M1       = (IMG_HEIGHT > VSYNC_LINES) ? IMG_HEIGHT : VSYNC_LINES;
  localparam int M2       = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
  localparam int MAXL     = (M1 > M2) ? M1 : M2;
  localparam int LW       = $clog2(MAXL + 1);
  localparam int BAR_W    = (IMG_WIDTH / 8 > 0) ? IMG_WIDTH / 8 : 1;
  localparam int BCW      = $clog2(BAR_W + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [LW-1:0]   line_q, line_d, last_line;
  pattern_t        pat_q, pat_d;
  logic [BCW-1:0]  bcnt_q, bcnt_d;
  logic [2:0]      bar_q, bar_d;
  logic            href_d, fd_d;
  logic [11:0]     rgb;

  always_comb begin
    case (state_q)
      ST_VSYNC:  last_line = LW'(VSYNC_LINES - 1);
      ST_VBACK:  last_line = LW'(V_BACK - 1);
      ST_ACTIVE: last_line = LW'(IMG_HEIGHT - 1);
      ST_VFRONT: last_line = LW'(V_FRONT - 1);
      default:   last_line = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    pat_d   = pat_q;
    if (state_q == ST_IDLE) begin
      if (enable) begin
        state_d = ST_VSYNC;
        pat_d   = pattern_t'(pattern_sel);
        col_d   = '0;
        line_d  = '0;
      end
    end else if (col_q == CW'(LINE_LEN - 1)) begin
      col_d = '0;
      if (line_q == last_line) begin
        line_d = '0;
        case (state_q)
          ST_VSYNC:  state_d = ST_VBACK;
          ST_VBACK:  state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_VFRONT;
          ST_VFRONT: begin
            if (enable) begin
              state_d = ST_VSYNC;
              pat_d   = pattern_t'(pattern_sel);
            end else begin
              state_d = ST_IDLE;
            end
          end
          default:   state_d = ST_IDLE;
        endcase
      end else begin
        line_d = line_q + 1'b1;
      end
    end else begin
      col_d = col_q + 1'b1;
    end
  end

  // Bar counter tracks x = col_d/2, stepping when a new pixel (even col) begins.
  always_comb begin
    bcnt_d = bcnt_q;
    bar_d  = bar_q;
    if (col_d == '0) begin
      bcnt_d = '0;
      bar_d  = '0;
    end else if (!col_d[0]) begin
      if (bcnt_q == BCW'(BAR_W - 1)) begin
        bcnt_d = '0;
        bar_d  = bar_q + 1'b1;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  assign href_d = (state_d == ST_ACTIVE) && (col_d < CW'(2 * IMG_WIDTH));
  assign fd_d   = (state_d == ST_VFRONT) && (line_d == LW'(V_FRONT - 1)) &&
                  (col_d == CW'(LINE_LEN - 1));

  ov7670_pattern_pixel #(
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_pixel (
    .x_i      (16'(col_d[CW-1:1])),
    .y_i      (16'(line_d)),
    .bar_i    (bar_d),
    .pattern_i(pat_q),
    .rgb_o    (rgb)
  );

  // Outputs are registered from next-state values so they align with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      line_q     <= '0;
      pat_q      <= PAT_BARS;
      bcnt_q     <= '0;
      bar_q      <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      d          <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      line_q     <= line_d;
      pat_q      <= pat_d;
      bcnt_q     <= bcnt_d;
      bar_q      <= bar_d;
      vsync      <= (state_d == ST_VSYNC);
      href       <= href_d;
      d          <= href_d ? pack_rgb444(rgb, col_d[0]) : '0;
      frame_done <= fd_d;
      busy       <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Scoreboard bench for ov7670_stream_gen: a frame-time reference model pushes
// expected data bytes; a monitor pops and compares on every href cycle.
module tb_ov7670_stream_gen;

  localparam int W     = 80;
  localparam int H     = 36;
  localparam int HB    = 4;
  localparam int VS    = 3;
  localparam int VB    = 2;
  localparam int VF    = 2;
  localparam int L     = 2 * W + HB;
  localparam int FRAME = (VS + VB + H + VF) * L;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] pattern_sel;
  logic       vsync, href, frame_done, busy;
  logic [7:0] d;

  always #5 clk = ~clk;

  ov7670_stream_gen #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .H_BLANK    (HB),
    .VSYNC_LINES(VS),
    .V_BACK     (VB),
    .V_FRONT    (VF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .vsync      (vsync),
    .href       (href),
    .d          (d),
    .frame_done (frame_done),
    .busy       (busy)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  bit run = 1'b0;
  int t = 0;
  int mpat = 0;
  bit e_vs, e_href, e_fd, e_busy;
  int fd_model = 0;
  int fd_dut   = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_byte(input int pat, input int x, input int y, input bit odd);
    int r, g, b, bar;
    r = 0; g = 0; b = 0;
    case (pat)
      0: begin
        bar = x / (W / 8);
        r = ((bar / 4) % 2 != 0) ? 15 : 0;
        g = ((bar / 2) % 2 != 0) ? 15 : 0;
        b = (bar % 2 != 0) ? 15 : 0;
      end
      1: begin
        r = (x / 16) % 16; g = r; b = r;
      end
      2: if (((x / 16) % 2) != ((y / 16) % 2)) begin r = 15; g = 15; b = 15; end
      default: if (y >= H / 2 && (x / 32) % 2 == 0) begin r = 15; g = 15; b = 15; end
    endcase
    return odd ? 8'(g * 16 + b) : 8'(r);
  endfunction

  // Reference model: position within the frame as a single cycle count.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        run = 1'b0;
      end else if (!run) begin
        if (enable) begin
          run = 1'b1; t = 0; mpat = int'(pattern_sel);
        end
      end else begin
        t++;
        if (t == FRAME) begin
          if (enable) begin
            t = 0; mpat = int'(pattern_sel);
          end else begin
            run = 1'b0;
          end
        end
      end
      e_vs = 0; e_href = 0; e_fd = 0; e_busy = 0;
      if (run) begin
        int line, col, al;
        line   = t / L;
        col    = t % L;
        al     = line - VS - VB;
        e_busy = 1;
        e_vs   = (line < VS);
        e_href = (al >= 0) && (al < H) && (col < 2 * W);
        e_fd   = (t == FRAME - 1);
        if (e_fd) fd_model++;
        if (e_href) exp_q.push_back(ref_byte(mpat, col / 2, al, col % 2 != 0));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("vsync", vsync, e_vs);
      check("href", href, e_href);
      check("frame_done", frame_done, e_fd);
      check("busy", busy, e_busy);
      if (frame_done) fd_dut++;
      if (href) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL data_unexpected: got %0h expected no byte at %0t", d, $time);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("d", d, e);
        end
      end else begin
        check("d_idle", d, 0);
      end
    end
  end

  int nxt[4] = '{1, 2, 3, 0};

  initial begin
    int w;
    rst_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    // Back-to-back frames; pattern_sel changes mid-frame and takes effect next frame.
    for (int k = 0; k < 4; k++) begin
      w = 2500 + int'($urandom_range(0, 1500));
      repeat (w) @(negedge clk);
      pattern_sel = 2'(nxt[k]);
      repeat (FRAME - w) @(negedge clk);
    end
    w = 2500 + int'($urandom_range(0, 1500));
    repeat (w) @(negedge clk);
    enable = 1'b0;
    pattern_sel = 2'($urandom_range(0, 3));
    repeat (FRAME - w + 200) @(negedge clk);

    pattern_sel = 2'($urandom_range(0, 3));
    enable = 1'b1;
    repeat (2000) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_vsync", vsync, 0);
    check("rst_href", href, 0);
    check("rst_d", d, 0);
    check("rst_busy", busy, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    enable = 1'b0;
    repeat (FRAME) @(negedge clk);

    check("frame_done_count", fd_dut, fd_model);
    check("leftover_bytes", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
